// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Shift opcodes are executed one bit per cycle by iterating the ALU.
module alu_scheduler #(
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_opcode,
  input  logic [31:0]        req0_a,
  input  logic [31:0]        req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_opcode,
  input  logic [31:0]        req1_a,
  input  logic [31:0]        req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_err,
  output logic [3:0]         alu_opcode,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic               alu_shift_amount,
  input  logic [31:0]        alu_result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         state;
  logic               last_served;
  logic [3:0]         cap_opcode;
  logic [31:0]        cap_a;
  logic [31:0]        cap_b;
  logic [SHAMT_W-1:0] cnt;
  logic [31:0]        acc;

  logic               grant0;
  logic               grant1;
  logic               accept;
  logic               sel;
  logic [3:0]         sel_opcode;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_is_shift;

  // last_served=1 means req0 wins a tie, which is the post-reset priority
  always_comb begin
    grant0       = req0_valid && (!req1_valid || last_served);
    grant1       = req1_valid && (!req0_valid || !last_served);
    req0_ready   = (state == IDLE) && !rst && grant0;
    req1_ready   = (state == IDLE) && !rst && grant1;
    accept       = req0_ready || req1_ready;
    sel          = req1_ready;
    sel_opcode   = sel ? req1_opcode : req0_opcode;
    sel_a        = sel ? req1_a      : req0_a;
    sel_b        = sel ? req1_b      : req0_b;
    sel_shamt    = sel ? req1_shamt  : req0_shamt;
    sel_is_shift = (sel_opcode == 4'b0110) || (sel_opcode == 4'b0111) ||
                   (sel_opcode == 4'b1000);
  end

  assign alu_opcode       = cap_opcode;
  assign alu_b            = cap_b;
  assign alu_a            = (state == SHIFT) ? acc : cap_a;
  assign alu_shift_amount = (state == SHIFT) && (cnt != '0);
  assign rsp_valid        = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      cap_opcode  <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      cnt         <= '0;
      acc         <= '0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_opcode <= sel_opcode;
            cap_a      <= sel_a;
            cap_b      <= sel_b;
            acc        <= sel_a;
            rsp_id     <= sel;
            cnt        <= sel_is_shift ? sel_shamt : '0;
            state      <= sel_is_shift ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          if (cap_opcode <= 4'd8) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
          state <= RESP;
        end
        // one ALU pass per remaining bit of shift count
        SHIFT: begin
          if (cnt != '0) begin
            acc <= alu_result;
            cnt <= cnt - CNT_ONE;
          end else begin
            rsp_result <= acc;
            rsp_err    <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            last_served <= rsp_id;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: directed scenarios then randomized traffic,
// with an external ALU model and a reference computed from whole-op arithmetic.
module tb_alu_scheduler;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_shift_amount;

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        err;
    int          due;
    int          shifts;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          last_hs = -10;
  int          m_last = 1;
  bit          hold_low = 0;
  logic [3:0]  m_op[2];
  logic [31:0] m_a[2];
  logic [31:0] m_b[2];
  logic [4:0]  m_sh[2];

  alu_scheduler #(.SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_shift_amount(alu_shift_amount), .alu_result(alu_result)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Shared ALU: shifts move by one bit only when alu_shift_amount is set
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_opcode)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = ~alu_a;
      4'd6: alu_result = alu_shift_amount ? (alu_a << 1) : alu_a;
      4'd7: alu_result = alu_shift_amount ? 32'($signed(alu_a) >>> 1) : alu_a;
      4'd8: alu_result = alu_shift_amount ? (alu_a >> 1) : alu_a;
      default: ;
    endcase
  end

  function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic setReq(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    if (n == 0) begin
      req0_opcode = op; req0_a = a; req0_b = b; req0_shamt = sh;
    end else begin
      req1_opcode = op; req1_a = a; req1_b = b; req1_shamt = sh;
    end
    m_op[n] = op; m_a[n] = a; m_b[n] = b; m_sh[n] = sh;
  endtask

  task automatic applyStimulus(input bit v0, input bit v1);
    int waited = 0;
    int win;
    logic act_win;
    bit shift_op;
    exp_t e;
    @(posedge clk); #1;
    if (v0) req0_valid = 1'b1;
    if (v1) req1_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!(req0_ready || req1_ready) && waited < 400);
    if (!(req0_ready || req1_ready)) begin
      checkOutput("accept_timeout", {31'd0, req0_ready || req1_ready}, 32'd1);
      return;
    end
    if (req0_valid && req1_valid) win = (m_last == 1) ? 0 : 1;
    else win = req0_valid ? 0 : 1;
    act_win = req1_ready;
    checkOutput("grant_one_hot", {31'd0, req0_ready && req1_ready}, 32'd0);
    checkOutput("grant_winner", {31'd0, req1_ready}, win);
    checkOutput("accept_spacing", {31'd0, (cycle > last_hs) && (exp_q.size() == 0)}, 32'd1);
    shift_op = (m_op[win] >= 4'd6) && (m_op[win] <= 4'd8);
    e.id     = win[0];
    e.err    = (m_op[win] > 4'd8);
    e.result = e.err ? 32'd0 : refResult(m_op[win], m_a[win], m_b[win], m_sh[win]);
    e.shifts = shift_op ? int'(m_sh[win]) : 0;
    e.due    = cycle + 2 + e.shifts;
    exp_q.push_back(e);
    m_last = win;
    @(posedge clk); #1;
    if (act_win) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("rst_rsp_result", rsp_result, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_shift", {31'd0, alu_shift_amount}, 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    m_last = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_hs = -10;
    @(negedge clk);
    checkResetState();
  endtask

  task automatic waitDrain();
    int w = 0;
    while (exp_q.size() != 0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);
  endtask

  function automatic logic [3:0] randOp();
    if ($urandom_range(0, 9) == 9) return 4'($urandom_range(9, 15));
    return 4'($urandom_range(0, 8));
  endfunction

  // Consumer: random backpressure unless a scenario pins rsp_ready low
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares each presented response against the queue head
  initial begin
    bit prev_valid = 0;
    int shift_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
        shift_cnt = 0;
      end else begin
        if (alu_shift_amount) shift_cnt++;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
          end else begin
            if (!prev_valid) checkOutput("rsp_latency", cycle, exp_q[0].due);
            checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
            checkOutput("rsp_result", rsp_result, exp_q[0].result);
            checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
            checkOutput("ready_in_resp", {31'd0, req0_ready || req1_ready}, 32'd0);
            if (rsp_ready) begin
              checkOutput("shift_cycles", shift_cnt, exp_q[0].shifts);
              void'(exp_q.pop_front());
              shift_cnt = 0;
              last_hs = cycle;
            end
          end
        end
        prev_valid = rsp_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    setReq(0, 4'd0, 32'd0, 32'd0, 5'd0);
    setReq(1, 4'd0, 32'd0, 32'd0, 5'd0);
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("ready_in_reset", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    checkResetState();

    $display("[TB] directed: ADD, SUB, SLA");
    setReq(0, 4'd0, 32'd5, 32'd7, 5'd0);
    applyStimulus(1, 0);
    setReq(1, 4'd1, 32'd3, 32'd5, 5'd0);
    applyStimulus(0, 1);
    setReq(0, 4'd6, 32'd1, 32'd0, 5'd4);
    applyStimulus(1, 0);
    setReq(0, 4'd6, 32'd1, 32'd0, 5'd0);
    applyStimulus(1, 0);
    waitDrain();

    $display("[TB] directed: round robin after reset");
    doReset();
    setReq(0, 4'd0, 32'd10, 32'd20, 5'd0);
    setReq(1, 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    repeat (4) applyStimulus(1, 1);
    waitDrain();

    $display("[TB] directed: illegal opcode with stalled consumer");
    hold_low = 1;
    setReq(0, 4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    applyStimulus(1, 0);
    w = 0;
    while (!rsp_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("illegal_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    setReq(0, 4'd3, 32'h00FF_0000, 32'h0000_00FF, 5'd0);
    setReq(1, 4'd5, 32'h0F0F_0F0F, 32'd0, 5'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (5) @(negedge clk);
    hold_low = 0;
    applyStimulus(1, 1);
    applyStimulus(1, 0);
    waitDrain();

    $display("[TB] directed: reset mid-shift");
    setReq(0, 4'd7, 32'h8000_0000, 32'd0, 5'd20);
    applyStimulus(1, 0);
    repeat (5) @(negedge clk);
    checkOutput("shift_active", {31'd0, alu_shift_amount}, 32'd1);
    doReset();
    repeat (3) @(negedge clk);
    setReq(1, 4'd0, 32'd100, 32'd23, 5'd0);
    applyStimulus(0, 1);
    waitDrain();

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      int r;
      bit v0, v1;
      r = $urandom_range(1, 3);
      v0 = r[0];
      v1 = r[1];
      if (v0 && !req0_valid) setReq(0, randOp(), $urandom, $urandom, 5'($urandom_range(0, 31)));
      if (v1 && !req1_valid) setReq(1, randOp(), $urandom, $urandom, 5'($urandom_range(0, 31)));
      applyStimulus(v0, v1);
    end
    if (req0_valid) applyStimulus(1, 0);
    if (req1_valid) applyStimulus(0, 1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter: SHAMT_W, default 5, width of the shift-count field; the block SHALL support 1..5.
REQ-002 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req0_valid, req1_valid  input  1  requester N presents an operation.
REQ-006 Port: req0_ready, req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-007 Port: reqN_opcode  input  4  ALU opcode for requester N (0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 SLA, 0111 SRA, 1000 SRL).
REQ-008 Port: reqN_a, reqN_b  input  32  operands for requester N.
REQ-009 Port: reqN_shamt  input  SHAMT_W  shift count for requester N; ignored for non-shift opcodes.
REQ-010 Port: rsp_valid  output  1  response available.
REQ-011 Port: rsp_ready  input  1  consumer accepts the response.
REQ-012 Port: rsp_id  output  1  index of the requester that owns the response.
REQ-013 Port: rsp_result  output  32  operation result.
REQ-014 Port: rsp_err  output  1  opcode was illegal (1001-1111).
REQ-015 Port: alu_opcode  output  4;  alu_a, alu_b  output  32;  alu_shift_amount  output  1: drive the shared combinational ALU.
REQ-016 Port: alu_result  input  32  combinational result of the shared ALU.

Function
REQ-017 The FSM SHALL have the states IDLE, EXEC, SHIFT and RESP.
REQ-018 reqN_ready SHALL be 1 only in IDLE, and only for the requester granted that cycle; at most one ready SHALL be high at a time.
REQ-019 Grant SHALL be round-robin: with one valid, that requester wins; with both valid, the requester not served last wins; after reset, req0 has priority.
REQ-020 On accept (valid&ready), the block SHALL capture opcode, a, b, shamt and the id.
REQ-021 On accept, the next state SHALL be SHIFT for opcodes 0110/0111/1000 (cnt=shamt, acc=a); otherwise it SHALL be EXEC.
REQ-022 EXEC SHALL last 1 cycle with alu_shift_amount=0.
REQ-023 In EXEC, a legal opcode SHALL register rsp_result=alu_result with rsp_err=0.
REQ-024 In EXEC, an illegal opcode SHALL register rsp_result=0 with rsp_err=1; the next state SHALL be RESP.
REQ-025 In SHIFT with cnt!=0, the block SHALL drive alu_a=acc with alu_shift_amount=1, then set acc<=alu_result and cnt<=cnt-1.
REQ-026 In SHIFT with cnt==0, the block SHALL set rsp_result<=acc and go to RESP without using the ALU.
REQ-027 Outside SHIFT, alu_a SHALL equal the captured a; alu_opcode and alu_b SHALL always equal the captured values.
REQ-028 alu_shift_amount SHALL be 0 in every state except SHIFT with cnt!=0.
REQ-029 Latency: accept in cycle T gives rsp_valid high in T+2 for non-shift ops, and in T+2+shamt for shift ops (shamt=0 gives T+2 with result=a).
REQ-030 In RESP, rsp_valid SHALL be 1, and rsp_id, rsp_result and rsp_err SHALL hold stable until rsp_ready=1.
REQ-031 On the RESP handshake, the block SHALL return to IDLE in the next cycle and record rsp_id as last-served.
REQ-032 No new request SHALL be accepted before the cycle after the RESP handshake; minimum spacing between accepts is 3 cycles.
REQ-033 Requests that are not accepted SHALL not be modified or dropped; requesters hold valid and payload until ready.
REQ-034 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-035 When rst=1 at a clock edge, the block SHALL set: state IDLE, last-served=1 (req0 priority), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, cnt=0, acc=0, and all captured operands and opcode to 0.
REQ-036 Reset during EXEC, SHIFT or RESP SHALL abort the operation without producing a response; reqN_ready SHALL be 0 while rst=1.

Verification
REQ-037 Stimulus: req0 ADD a=5, b=7, accepted in T -> rsp_valid in T+2, rsp_result=12, rsp_id=0, rsp_err=0.
REQ-038 Stimulus: req1 SUB a=3, b=5 -> rsp_result=0xFFFFFFFE, rsp_id=1.
REQ-039 Stimulus: req0 SLA a=1, shamt=4 -> alu_shift_amount=1 for exactly 4 cycles, rsp_valid at T+6, rsp_result=16; with shamt=0 -> rsp_result=1 at T+2.
REQ-040 Stimulus: both valid and held for 4 ops after reset -> grant order 0,1,0,1 with correct rsp_id each time.
REQ-041 Stimulus: opcode 1011 -> rsp_err=1, rsp_result=0; rsp_ready held low 5 cycles -> response stable, neither ready asserted.
REQ-042 Stimulus: rst pulsed mid-SHIFT (shamt=20) -> no rsp_valid; next cycle IDLE with all outputs at their reset values; next req1-only request accepted normally.
